// File: rtl/bsg_cgol_ctrl.sv
// Game of Life sequencing controller: accepts a board + generation count, loads the
// cell array, steps it, then offers the final board. Define CGOL_CTRL_STABLE_EXIT_EN
// to stop early once a generation leaves the board unchanged.
module bsg_cgol_ctrl #(
  parameter int board_width_p = 8,
  parameter int max_frames_p  = 1024,
  localparam int b_lp = board_width_p * board_width_p,
  localparam int f_lp = $clog2(max_frames_p + 1)
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [b_lp-1:0] data_i,
  input  logic [f_lp-1:0] frames_i,
  input  logic            v_i,
  output logic            ready_o,
  output logic            en_o,
  output logic            update_o,
  output logic [b_lp-1:0] update_val_o,
  input  logic [b_lp-1:0] cells_i,
  output logic [b_lp-1:0] data_o,
  output logic [f_lp-1:0] gens_o,
  output logic            v_o,
  input  logic            yumi_i,
  output logic [1:0]      state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SIM  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state_r;
  logic [b_lp-1:0] board_r;
  logic [f_lp-1:0] cnt_r;
  logic [f_lp-1:0] gens_r;
  logic            stable_hit;
  logic            sim_stop;

`ifdef CGOL_CTRL_STABLE_EXIT_EN
  logic [b_lp-1:0] snap_r;
  logic            first_r;

  // The first SIM cycle has no previous snapshot, so comparison waits one cycle.
  assign stable_hit = (state_r == SIM) && !first_r && (cells_i == snap_r);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      snap_r  <= '0;
      first_r <= 1'b0;
    end else begin
      if (state_r == LOAD) first_r <= 1'b1;
      else if (state_r == SIM) first_r <= 1'b0;
      if (state_r == SIM) snap_r <= cells_i;
    end
  end
`else
  assign stable_hit = 1'b0;
`endif

  assign sim_stop = (cnt_r == '0) || stable_hit;

  // Handshakes: a job is taken on a rising edge where v_i && ready_o; a result
  // is retired on a rising edge where v_o && yumi_i. Neither side may retract
  // outside those rules, and v_i / yumi_i are ignored outside IDLE / DONE.
  assign ready_o      = (state_r == IDLE);
  assign update_o     = (state_r == LOAD);
  assign en_o         = (state_r == SIM) && !sim_stop;
  assign v_o          = (state_r == DONE);
  assign update_val_o = board_r;
  assign data_o       = cells_i;
  assign gens_o       = gens_r;
  assign state_o      = state_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      board_r <= '0;
      cnt_r   <= '0;
      gens_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            board_r <= data_i;
            cnt_r   <= frames_i;
            gens_r  <= '0;
            state_r <= LOAD;
          end
        end
        LOAD: state_r <= SIM;
        SIM: begin
          if (sim_stop) begin
            state_r <= DONE;
          end else begin
            cnt_r  <= cnt_r - 1'b1;
            gens_r <= gens_r + 1'b1;
          end
        end
        DONE: begin
          if (yumi_i) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
